// File: rtl/roll_light_scheduler.sv
// Display arbiter between the dice and traffic-light datapaths: the lights run by default,
// and a roll request hands the display to the dice for a roll and a hold period.
module roll_light_scheduler #(
    parameter int unsigned LIGHT_DIV   = 4,
    parameter int unsigned ROLL_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned MIN_LIGHT   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_req,
    input  logic [2:0] dice_val,
    input  logic [2:0] light_val,
    output logic       dice_button,
    output logic       light_en,
    output logic       sel,
    output logic [2:0] result,
    output logic       busy
);

    localparam int unsigned DIV_W   = $clog2(LIGHT_DIV + 1);
    localparam int unsigned ROLL_W  = $clog2(ROLL_CYCLES + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DWELL_W = $clog2(MIN_LIGHT + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(LIGHT_DIV - 1);
    localparam logic [ROLL_W-1:0]  ROLL_LAST = ROLL_W'(ROLL_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_LIGHT);

    typedef enum logic [1:0] {
        ST_LIGHT,
        ST_ROLL,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt,   w_div_nxt;
    logic [ROLL_W-1:0]  r_roll_cnt,  w_roll_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt,  w_hold_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_nxt;
    logic               r_pending,   w_pending_nxt;
    logic               r_light_en,  w_light_en_nxt;
    logic [2:0]         r_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_LIGHT;
            r_div_cnt   <= '0;
            r_roll_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_dwell_cnt <= DWELL_MAX;
            r_pending   <= 1'b0;
            r_light_en  <= 1'b0;
            r_result    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_roll_cnt  <= w_roll_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_pending   <= w_pending_nxt;
            r_light_en  <= w_light_en_nxt;
            r_result    <= sel ? light_val : dice_val;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div_cnt;
        w_roll_nxt     = r_roll_cnt;
        w_hold_nxt     = r_hold_cnt;
        w_dwell_nxt    = r_dwell_cnt;
        w_pending_nxt  = r_pending;
        w_light_en_nxt = 1'b0;

        case (r_state)
            ST_LIGHT: begin
                w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
                if (r_dwell_cnt != DWELL_MAX) begin
                    w_dwell_nxt = r_dwell_cnt + 1'b1;
                end
                if ((roll_req || r_pending) && (r_dwell_cnt == DWELL_MAX)) begin
                    w_state_nxt   = ST_ROLL;
                    w_pending_nxt = 1'b0;
                    w_roll_nxt    = '0;
                end else begin
                    // Reaching here with a request means the dwell has not yet expired.
                    if (roll_req) begin
                        w_pending_nxt = 1'b1;
                    end
                    w_light_en_nxt = (r_div_cnt == DIV_LAST);
                end
            end
            ST_ROLL: begin
                if (r_roll_cnt == ROLL_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = '0;
                end else begin
                    w_roll_nxt = r_roll_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (roll_req) begin
                    w_state_nxt = ST_ROLL;
                    w_roll_nxt  = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_LIGHT;
                    w_div_nxt   = '0;
                    w_dwell_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LIGHT;
            end
        endcase
    end

    assign sel         = (r_state == ST_LIGHT);
    assign dice_button = (r_state == ST_ROLL);
    assign busy        = (r_state != ST_LIGHT);
    assign light_en    = r_light_en;
    assign result      = r_result;

endmodule

// File: tb/tb_roll_light_scheduler.sv
// Directed bench for roll_light_scheduler: reset, light pacing, roll/hold timing,
// dwell arbitration, re-roll, simultaneous expiry and asynchronous reset.
module tb_roll_light_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll_req;
    logic [2:0] dice_val;
    logic [2:0] light_val;
    logic       dice_button;
    logic       light_en;
    logic       sel;
    logic [2:0] result;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    roll_light_scheduler #(
        .LIGHT_DIV   (4),
        .ROLL_CYCLES (8),
        .HOLD_CYCLES (16),
        .MIN_LIGHT   (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .roll_req    (roll_req),
        .dice_val    (dice_val),
        .light_val   (light_val),
        .dice_button (dice_button),
        .light_en    (light_en),
        .sel         (sel),
        .result      (result),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;
        rst       = 1'b0;
        roll_req  = 1'b0;
        light_val = 3'd5;
        dice_val  = 3'd2;

        repeat (3) step();
        chk("rst_sel", 8'(sel), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_dice_button", 8'(dice_button), 8'd0);
        chk("rst_light_en", 8'(light_en), 8'd0);
        chk("rst_result", 8'(result), 8'd0);

        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("light_pulse", 8'(light_en), (k % 4 == 0) ? 8'd1 : 8'd0);
            if (k == 1) chk("res_first", 8'(result), 8'd5);
        end
        light_val = 3'd3;
        chk("res_latency", 8'(result), 8'd5);
        step();
        chk("res_track", 8'(result), 8'd3);

        // single roll: request in cycle T, ROLL 1..8, HOLD 9..24
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            chk("roll_button", 8'(dice_button), (i <= 8) ? 8'd1 : 8'd0);
            chk("roll_sel", 8'(sel), 8'd0);
            chk("roll_busy", 8'(busy), 8'd1);
            chk("roll_freeze", 8'(light_en), 8'd0);
            if (i == 2) chk("res_dice", 8'(result), 8'd2);
            step();
        end
        chk("ret_sel", 8'(sel), 8'd1);
        chk("ret_busy", 8'(busy), 8'd0);
        chk("ret_res_lag", 8'(result), 8'd2);
        step();
        chk("ret_res_light", 8'(result), 8'd3);
        step();
        step();
        chk("ret_no_pulse", 8'(light_en), 8'd0);
        step();
        chk("ret_pulse", 8'(light_en), 8'd1);

        // dwell: request at LIGHT cycle 5 waits for the dwell to saturate
        step();
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        chk("dwell_busy", 8'(busy), 8'd0);
        chk("dwell_sel", 8'(sel), 8'd1);
        m = 0;
        while (!busy && m <= 40) begin
            step();
            m++;
        end
        chk("dwell_len", 8'(6 + m), 8'd21);

        // request mid-ROLL is ignored
        for (int r = 1; r <= 8; r++) begin
            chk("ign_button", 8'(dice_button), 8'd1);
            if (r == 4) roll_req = 1'b1;
            if (r == 6) roll_req = 1'b0;
            step();
        end
        for (int h = 1; h <= 10; h++) begin
            chk("hold_button", 8'(dice_button), 8'd0);
            chk("hold_sel", 8'(sel), 8'd0);
            chk("hold_freeze", 8'(light_en), 8'd0);
            if (h < 10) step();
        end

        // re-roll from HOLD cycle 10
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            chk("reroll_button", 8'(dice_button), 8'd1);
            step();
        end
        chk("reroll_end", 8'(dice_button), 8'd0);
        for (int h = 1; h <= 15; h++) begin
            chk("hold2_busy", 8'(busy), 8'd1);
            step();
        end

        // request on final HOLD cycle wins over return to LIGHT
        chk("last_hold_sel", 8'(sel), 8'd0);
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        chk("simul_button", 8'(dice_button), 8'd1);
        chk("simul_sel", 8'(sel), 8'd0);

        // asynchronous reset between edges mid-ROLL
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_button", 8'(dice_button), 8'd0);
        chk("arst_sel", 8'(sel), 8'd1);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_result", 8'(result), 8'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("post_rst_sel", 8'(sel), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
